// File: rtl/gat_feat_reader.sv
// Streams the GAT new-feature BRAM out over a valid/ready master port, credit-limited by a FIFO.
// Optional FEAT_READER_ROW_LAST_EN adds m_tuser_rowlast marking the last word of each row.
module gat_feat_reader #(
  parameter int unsigned NEW_FEATURE_WIDTH  = 32,
  parameter int unsigned NUM_SUBGRAPHS      = 2708,
  parameter int unsigned NUM_FEATURE_OUT    = 16,
  parameter int unsigned NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  parameter int unsigned NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int unsigned BRAM_LATENCY       = 2,
  parameter int unsigned FIFO_DEPTH         = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic [NEW_FEATURE_ADDR_W+1:0]   feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]    feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]    m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            m_tlast,
`ifdef FEAT_READER_ROW_LAST_EN
  output logic                            m_tuser_rowlast,
`endif
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned CntW = NEW_FEATURE_ADDR_W + 1;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CrW  = $clog2(FIFO_DEPTH + BRAM_LATENCY + 2) + 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(NEW_FEATURE_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                         state_q, state_d;
  logic [CntW-1:0]                rd_idx_q, rd_idx_d;
  logic [CntW-1:0]                out_idx_q, out_idx_d;
  logic [NEW_FEATURE_ADDR_W+1:0]  addrb_q, addrb_d;
  // tag_q[0] pairs with addrb_q; tag_q[BRAM_LATENCY] marks dout valid this cycle.
  logic [BRAM_LATENCY:0]          tag_q, tag_d;
  logic [NEW_FEATURE_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]                wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CrW-1:0]                 count_q, count_d;
  logic [CrW-1:0]                 inflight;
  logic                           push, pop, issue, credit_ok;

  assign push      = tag_q[BRAM_LATENCY];
  assign m_tvalid  = (count_q != '0);
  assign m_tdata   = mem_q[rptr_q];
  assign pop       = m_tvalid && m_tready;
  assign m_tlast   = m_tvalid && (out_idx_q == LastIdx);
  assign feat_bram_addrb = addrb_q;
  assign busy      = (state_q == StIssue) || (state_q == StDrain);
  assign done      = (state_q == StDone);

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= int'(BRAM_LATENCY); i++) begin
      inflight = inflight + CrW'(tag_q[i]);
    end
  end

  // A pop this cycle frees its slot in time for an issue in the same cycle.
  assign credit_ok = (inflight + count_q - CrW'(pop)) < CrW'(FIFO_DEPTH);

  always_comb begin
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    out_idx_d = out_idx_q;
    addrb_d   = addrb_q;
    issue     = 1'b0;
    if (pop) begin
      out_idx_d = out_idx_q + 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StIssue;
          rd_idx_d  = '0;
          out_idx_d = '0;
        end
      end
      StIssue: begin
        if (credit_ok) begin
          issue    = 1'b1;
          addrb_d  = {rd_idx_q[NEW_FEATURE_ADDR_W-1:0], 2'b00};
          rd_idx_d = rd_idx_q + 1'b1;
          if (rd_idx_q == LastIdx) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && (out_idx_q == LastIdx)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tag_d   = {tag_q[BRAM_LATENCY-1:0], issue};
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q + CrW'(push) - CrW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rd_idx_q  <= '0;
      out_idx_q <= '0;
      addrb_q   <= '0;
      tag_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rd_idx_q  <= rd_idx_d;
      out_idx_q <= out_idx_d;
      addrb_q   <= addrb_d;
      tag_q     <= tag_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      if (push) begin
        mem_q[wptr_q] <= feat_bram_dout;
      end
    end
  end

`ifdef FEAT_READER_ROW_LAST_EN
  localparam int unsigned RowW = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
  localparam logic [RowW-1:0] RowLast = RowW'(NUM_FEATURE_OUT - 1);

  logic [RowW-1:0] row_q, row_d;

  always_comb begin
    row_d = row_q;
    if (state_q == StIdle && start) begin
      row_d = '0;
    end else if (pop) begin
      row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q <= '0;
    end else begin
      row_q <= row_d;
    end
  end

  assign m_tuser_rowlast = m_tvalid && (row_q == RowLast);
`endif

endmodule

// File: tb/tb_gat_feat_reader.sv
// Directed bench for gat_feat_reader with 3x4 words and a two-cycle-latency BRAM model.
module tb_gat_feat_reader;

  localparam int Depth = 12;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  addrb;
  logic [31:0] dout;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        busy;
  logic        done;
`ifdef FEAT_READER_ROW_LAST_EN
  logic        rowlast;
`endif

  logic [31:0] bram_p1;
  int tests = 0;
  int fails = 0;

  gat_feat_reader #(
    .NEW_FEATURE_WIDTH (32),
    .NUM_SUBGRAPHS     (3),
    .NUM_FEATURE_OUT   (4),
    .NEW_FEATURE_DEPTH (12),
    .NEW_FEATURE_ADDR_W(4),
    .BRAM_LATENCY      (2),
    .FIFO_DEPTH        (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .feat_bram_addrb(addrb),
    .feat_bram_dout (dout),
    .m_tdata        (m_tdata),
    .m_tvalid       (m_tvalid),
    .m_tready       (m_tready),
    .m_tlast        (m_tlast),
`ifdef FEAT_READER_ROW_LAST_EN
    .m_tuser_rowlast(rowlast),
`endif
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-stage BRAM: mem[i] = 0x100 + i, valid two edges after addrb changes.
  always @(posedge clk) begin
    bram_p1 <= 32'h100 + (32'(addrb) >> 2);
    dout    <= bram_p1;
  end

  typedef struct {
    int          mode;      // 0: ready=1, 1: ready 1,0,0,1, 2: ready=0 for 20 cycles
    int          sa;        // extra start pulse cycles (-1 = none)
    int          sb;
    int          exp_words;
    int          exp_dones;
    logic [31:0] exp_addr_end;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " addrb"}, 32'(addrb), 32'h0);
    check({tag, " tvalid"}, 32'(m_tvalid), 32'h0);
    check({tag, " tlast"}, 32'(m_tlast), 32'h0);
    check({tag, " tdata"}, m_tdata, 32'h0);
    check({tag, " busy"}, 32'(busy), 32'h0);
    check({tag, " done"}, 32'(done), 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int n;
    int cyc;
    int dones;
    int hs_cyc;
    int done_cyc;
    logic [31:0] prev_data;
    logic        prev_stall;
    logic [5:0]  prev_addr;
    logic [5:0]  exp_addr;
    logic        r;
    n = 0; dones = 0; hs_cyc = -10; done_cyc = -1;
    prev_data = '0; prev_stall = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    m_tready = (v.mode != 2);
    prev_addr = addrb;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 300 && !(done_cyc >= 0 && cyc > done_cyc + 4)) begin
      case (v.mode)
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        2:       r = (cyc > 20);
        default: r = 1'b1;
      endcase
      m_tready = r;
      if (v.mode == 2 && cyc == 20) check({nm, " addrb after stall"}, 32'(addrb), 32'h0C);
      if (addrb != prev_addr) begin
        exp_addr = (prev_addr == 6'h2C) ? 6'h00 : prev_addr + 6'd4;
        check({nm, " addrb step"}, 32'(addrb), 32'(exp_addr));
      end
      prev_addr = addrb;
      if (prev_stall) begin
        check({nm, " stall tvalid"}, 32'(m_tvalid), 32'h1);
        check({nm, " stall tdata"}, m_tdata, prev_data);
      end
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
        check({nm, " done cycle"}, 32'(cyc), 32'(hs_cyc + 1));
      end
      check({nm, " tlast"}, 32'(m_tlast), 32'(m_tvalid && (n == Depth - 1)));
`ifdef FEAT_READER_ROW_LAST_EN
      check({nm, " rowlast"}, 32'(rowlast), 32'(m_tvalid && (n % 4 == 3)));
`endif
      if (m_tvalid) begin
        check({nm, " tdata"}, m_tdata, 32'h100 + 32'(n));
        if (m_tready) begin
          n++;
          hs_cyc = cyc;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      start = (cyc == v.sa) || (cyc == v.sb);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({nm, " timeout"}, 32'(cyc >= 300), 32'h0);
    check({nm, " word count"}, 32'(n), 32'(v.exp_words));
    check({nm, " done count"}, 32'(dones), 32'(v.exp_dones));
    check({nm, " busy at end"}, 32'(busy), 32'h0);
    check({nm, " final addrb"}, 32'(addrb), v.exp_addr_end);
  endtask

  task automatic reset_mid_run();
    int n;
    int cyc;
    int dones;
    n = 0; cyc = 0; dones = 0;
    @(posedge clk); #1;
    start = 1'b1;
    m_tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (n < 6 && cyc < 100) begin
      if (m_tvalid && m_tready) n++;
      @(posedge clk); #1;
      cyc++;
    end
    check("reset: reached 6 words", 32'(n), 32'd6);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("mid reset");
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    check("mid reset no done", 32'(dones), 32'h0);
    check("mid reset stays idle", 32'(busy), 32'h0);
  endtask

  initial begin
    vecs[0] = '{mode: 0, sa: -1, sb: -1, exp_words: 12, exp_dones: 1, exp_addr_end: 32'h2C};
    vecs[1] = '{mode: 1, sa: -1, sb: -1, exp_words: 12, exp_dones: 1, exp_addr_end: 32'h2C};
    vecs[2] = '{mode: 2, sa: -1, sb: -1, exp_words: 12, exp_dones: 1, exp_addr_end: 32'h2C};
    vecs[3] = '{mode: 0, sa: 5,  sb: 8,  exp_words: 12, exp_dones: 1, exp_addr_end: 32'h2C};

    rst_n = 1'b0;
    start = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("power-on reset");
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    reset_mid_run();
    run_vec(vecs[0], "after reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
